sync_fifo_param: RTL and testbench

Parametrised single-clock FIFO that succeeds the fixed 128-bit FIFO behind `fifo_interface`. It adds:
- configurable data width and depth;
- parameter-set almost-full/almost-empty thresholds;
- an occupancy count output;
- sticky overflow/underflow error flags;
- a synchronous flush.

It sits between a producer and a consumer in one clock domain and keeps the existing `i_wren`/`i_rden`/flag port semantics, so current UVM drivers and monitors attach unchanged.

---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_mem_2p.sv | 62 ++++++
 rtl/sync_fifo_param.sv | 148 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_pkg : shared defaults, count-width helper and status struct     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package fifo_pkg;

  localparam int FIFO_DATA_W = 128;
  localparam int FIFO_DEPTH  = 16;

  typedef struct packed {
    logic full;
    logic alm_full;
    logic empty;
    logic alm_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_mem_2p.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_mem_2p : 1W/1R storage array; registered read by default,       |
// | asynchronous read when SYNC_FIFO_FWFT_EN is defined.                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module fifo_mem_2p
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
`ifndef SYNC_FIFO_FWFT_EN
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_re,
`endif
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  // Storage is deliberately left without reset; occupancy gates visibility.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rdata = mem_q[i_raddr];
`else
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (i_clr) begin
      rdata_d = '0;
    end else if (i_re) begin
      rdata_d = mem_q[i_raddr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign o_rdata = rdata_q;
`endif

endmodule
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_param : parametrised single-clock FIFO with thresholds,    |
// | occupancy count, sticky errors and flush. Macro: SYNC_FIFO_FWFT_EN.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W        = FIFO_DATA_W,
  parameter int DEPTH         = FIFO_DEPTH,
  parameter int ALM_FULL_THR  = DEPTH - 2,
  parameter int ALM_EMPTY_THR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr,
  input  logic                     i_wren,
  input  logic [DATA_W-1:0]        i_wrdata,
  input  logic                     i_rden,
  output logic [DATA_W-1:0]        o_rddata,
  output logic                     o_full,
  output logic                     o_alm_full,
  output logic                     o_empty,
  output logic                     o_alm_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = cnt_w(DEPTH);
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_AF_CNT   = c_CNT_W'(ALM_FULL_THR);
  localparam logic [c_CNT_W-1:0] c_AE_CNT   = c_CNT_W'(ALM_EMPTY_THR);

  generate
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("sync_fifo_param: DEPTH must be a power of two and >= 4");
    end
    if (DATA_W < 1) begin : g_chk_width
      $error("sync_fifo_param: DATA_W must be >= 1");
    end
    if ((ALM_FULL_THR < 1) || (ALM_FULL_THR > DEPTH)) begin : g_chk_af
      $error("sync_fifo_param: ALM_FULL_THR out of range 1..DEPTH");
    end
    if ((ALM_EMPTY_THR < 0) || (ALM_EMPTY_THR > DEPTH - 1)) begin : g_chk_ae
      $error("sync_fifo_param: ALM_EMPTY_THR out of range 0..DEPTH-1");
    end
  endgenerate

  logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;
  logic               w_wr_acc, w_rd_acc;
  logic [DATA_W-1:0]  w_mem_rdata;
  fifo_status_t       w_status;

  always_comb begin
    w_status.full      = (count_q == c_FULL_CNT);
    w_status.alm_full  = (count_q >= c_AF_CNT);
    w_status.empty     = (count_q == '0);
    w_status.alm_empty = (count_q <= c_AE_CNT);
    w_status.overflow  = overflow_q;
    w_status.underflow = underflow_q;
  end

  // Flush masks both requests so a flushing cycle neither stores nor pops.
  assign w_wr_acc = i_wren && !w_status.full  && !i_clr;
  assign w_rd_acc = i_rden && !w_status.empty && !i_clr;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (i_clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (w_wr_acc) wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
      if (w_rd_acc) rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
      if (i_wren && w_status.full)  overflow_d  = 1'b1;
      if (i_rden && w_status.empty) underflow_d = 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   count_d = count_q + c_CNT_W'(1);
        2'b01:   count_d = count_q - c_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (c_PTR_W)
  ) u_mem (
    .clk     (clk),
`ifndef SYNC_FIFO_FWFT_EN
    .reset   (reset),
    .i_clr   (i_clr),
    .i_re    (w_rd_acc),
`endif
    .i_we    (w_wr_acc),
    .i_waddr (wr_ptr_q),
    .i_wdata (i_wrdata),
    .i_raddr (rd_ptr_q),
    .o_rdata (w_mem_rdata)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign o_rddata = w_status.empty ? '0 : w_mem_rdata;
`else
  assign o_rddata = w_mem_rdata;
`endif

  assign o_full      = w_status.full;
  assign o_alm_full  = w_status.alm_full;
  assign o_empty     = w_status.empty;
  assign o_alm_empty = w_status.alm_empty;
  assign o_overflow  = w_status.overflow;
  assign o_underflow = w_status.underflow;
  assign o_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_fifo_param : directed self-checking bench for sync_fifo_param|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sync_fifo_param;

  localparam int DATA_W = 128;
  localparam int DEPTH  = 16;
  localparam int AF_THR = 14;
  localparam int AE_THR = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_clr;
  logic              i_wren;
  logic              i_rden;
  logic [DATA_W-1:0] i_wrdata;
  logic [DATA_W-1:0] o_rddata;
  logic              o_full, o_alm_full, o_empty, o_alm_empty;
  logic [4:0]        o_count;
  logic              o_overflow, o_underflow;

  int n_assert = 0;
  int n_fail   = 0;
  logic [127:0] sb[$];
  logic [127:0] d;
  logic [127:0] exp_v;

  sync_fifo_param #(
    .DATA_W        (DATA_W),
    .DEPTH         (DEPTH),
    .ALM_FULL_THR  (AF_THR),
    .ALM_EMPTY_THR (AE_THR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (i_clr),
    .i_wren      (i_wren),
    .i_wrdata    (i_wrdata),
    .i_rden      (i_rden),
    .o_rddata    (o_rddata),
    .o_full      (o_full),
    .o_alm_full  (o_alm_full),
    .o_empty     (o_empty),
    .o_alm_empty (o_alm_empty),
    .o_count     (o_count),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_level(input string tag, input int c);
    chk({tag, ".count"},     128'(o_count),     128'(c));
    chk({tag, ".full"},      128'(o_full),      128'(c == DEPTH));
    chk({tag, ".alm_full"},  128'(o_alm_full),  128'(c >= AF_THR));
    chk({tag, ".empty"},     128'(o_empty),     128'(c == 0));
    chk({tag, ".alm_empty"}, 128'(o_alm_empty), 128'(c <= AE_THR));
  endtask

  task automatic cyc(input logic wr, input logic [127:0] wd, input logic rd, input logic clr);
    i_wren   = wr;
    i_wrdata = wd;
    i_rden   = rd;
    i_clr    = clr;
    @(posedge clk);
    #1;
    i_wren = 1'b0;
    i_rden = 1'b0;
    i_clr  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [127:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, o_rddata, exp);
    cyc(1'b0, '0, 1'b1, 1'b0);
`else
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk(tag, o_rddata, exp);
`endif
  endtask

  task automatic wrrd_chk(input string tag, input logic [127:0] wd, input logic [127:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    chk(tag, o_rddata, exp);
    cyc(1'b1, wd, 1'b1, 1'b0);
`else
    cyc(1'b1, wd, 1'b1, 1'b0);
    chk(tag, o_rddata, exp);
`endif
  endtask

  initial begin
    reset = 1'b1; i_clr = 1'b0; i_wren = 1'b0; i_rden = 1'b0; i_wrdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rddata", o_rddata, 128'h0);
    chk_level("rst", 0);
    chk("rst.ovf", 128'(o_overflow), 128'h0);
    chk("rst.udf", 128'(o_underflow), 128'h0);
    reset = 1'b0;

    // Fill 0x1..0x10 and watch each threshold crossing.
    for (int k = 1; k <= 16; k++) begin
      cyc(1'b1, 128'(k), 1'b0, 1'b0);
      chk_level($sformatf("fill%0d", k), k);
    end

    // Write+read while full: write dropped, read of 0x1 accepted.
`ifdef SYNC_FIFO_FWFT_EN
    chk("ovf.head", o_rddata, 128'h1);
    cyc(1'b1, 128'hAA, 1'b1, 1'b0);
`else
    cyc(1'b1, 128'hAA, 1'b1, 1'b0);
    chk("ovf.rddata", o_rddata, 128'h1);
`endif
    chk_level("ovf", 15);
    chk("ovf.flag", 128'(o_overflow), 128'h1);
    chk("ovf.udf", 128'(o_underflow), 128'h0);

    for (int k = 2; k <= 16; k++) rd_chk($sformatf("drain%0d", k), 128'(k));
    chk_level("drained", 0);
    chk("ovf.sticky", 128'(o_overflow), 128'h1);

    // Read+write while empty: read dropped, write accepted.
`ifdef SYNC_FIFO_FWFT_EN
    chk("udf.pre", o_rddata, 128'h0);
    cyc(1'b1, 128'h55, 1'b1, 1'b0);
    chk("udf.rddata", o_rddata, 128'h55);
`else
    cyc(1'b1, 128'h55, 1'b1, 1'b0);
    chk("udf.rddata", o_rddata, 128'h10);
`endif
    chk("udf.flag", 128'(o_underflow), 128'h1);
    chk_level("udf", 1);
    rd_chk("udf.pop", 128'h55);

    // Asynchronous reset at count 7 with both sticky flags set.
    for (int k = 0; k < 7; k++) cyc(1'b1, 128'h100 + 128'(k), 1'b0, 1'b0);
    chk_level("pre_rst", 7);
    chk("pre_rst.ovf", 128'(o_overflow), 128'h1);
    chk("pre_rst.udf", 128'(o_underflow), 128'h1);
    #2 reset = 1'b1;
    #1;
    chk("midrst.rddata", o_rddata, 128'h0);
    chk_level("midrst", 0);
    chk("midrst.ovf", 128'(o_overflow), 128'h0);
    chk("midrst.udf", 128'(o_underflow), 128'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_level("postrst", 0);

    // Steady state at count 8 with wrap-around.
    for (int k = 0; k < 8; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      sb.push_back(d);
      cyc(1'b1, d, 1'b0, 1'b0);
    end
    chk_level("steady0", 8);
    for (int k = 0; k < 100; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      exp_v = sb.pop_front();
      sb.push_back(d);
      wrrd_chk($sformatf("steady%0d", k), d, exp_v);
      chk($sformatf("steady%0d.count", k), 128'(o_count), 128'd8);
    end
    for (int k = 0; k < 8; k++) begin
      exp_v = sb.pop_front();
      rd_chk($sformatf("sdrain%0d", k), exp_v);
    end
    chk_level("sdrain", 0);

    // Set both sticky flags, then flush at count 10 with a write pending.
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("udf2.flag", 128'(o_underflow), 128'h1);
    for (int k = 0; k < 16; k++) cyc(1'b1, 128'h200 + 128'(k), 1'b0, 1'b0);
    cyc(1'b1, 128'hBB, 1'b0, 1'b0);
    chk("ovf2.flag", 128'(o_overflow), 128'h1);
    chk_level("ovf2", 16);
    for (int k = 0; k < 6; k++) rd_chk($sformatf("pre_clr%0d", k), 128'h200 + 128'(k));
    chk_level("pre_clr", 10);
    cyc(1'b1, 128'hCC, 1'b0, 1'b1);
    chk_level("clr", 0);
    chk("clr.ovf", 128'(o_overflow), 128'h0);
    chk("clr.udf", 128'(o_underflow), 128'h0);
    chk("clr.rddata", o_rddata, 128'h0);
    cyc(1'b0, '0, 1'b0, 1'b0);
    chk_level("post_clr", 0);
    cyc(1'b1, 128'hDD, 1'b0, 1'b0);
    rd_chk("post_clr.data", 128'hDD);
    chk_level("final", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
